imem_port_arbiter: RTL and testbench

- Shares the single-port, word-organised instruction memory between two requesters: the CPU fetch stage (read-only) and the program loader/debug port (read/write).
- Round-robin arbitration with a two-state FSM. Memory-side outputs are registered.
- Memory has synchronous read: data is valid the cycle after mem_en.
- Byte addresses are converted to word indices (addr >> 2).

---
 rtl/imem_port_arbiter.sv | 117 +++++++++++
 tb/tb_imem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing a single-port instruction memory between CPU fetch and loader/debug.
// Latency: req in IDLE -> gnt/mem_en next cycle -> rvalid the cycle after; one access per 2 cycles.
// Backpressure: requesters hold req until their gnt pulse. IMEM_BOOT_HOLD_EN masks fetch until l_done.
module imem_port_arbiter #(
    parameter int DEPTH_W = 5,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               f_req,
    input  logic [31:0]        f_addr,
    output logic               f_gnt,
    output logic               f_rvalid,
    output logic [DATA_W-1:0]  f_rdata,
    input  logic               l_req,
    input  logic               l_we,
    input  logic [31:0]        l_addr,
    input  logic [DATA_W-1:0]  l_wdata,
    input  logic               l_done,
    output logic               l_gnt,
    output logic               l_rvalid,
    output logic [DATA_W-1:0]  l_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [DEPTH_W-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic {FETCH, LOADER} who_t;

    state_t            state;
    who_t              last_winner;
    logic              f_pend, l_pend;
    logic [DATA_W-1:0] f_hold, l_hold;
    logic              f_elig, f_win;

    // Address bits outside the word index are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{f_addr[31:DEPTH_W+2], f_addr[1:0],
                           l_addr[31:DEPTH_W+2], l_addr[1:0], l_done};

`ifdef IMEM_BOOT_HOLD_EN
    logic boot_done;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            boot_done <= 1'b0;
        else if (l_done)
            boot_done <= 1'b1;
    end
    assign f_elig = f_req & boot_done;
`else
    assign f_elig = f_req;
`endif

    assign f_win = f_elig & (~l_req | (last_winner == LOADER));

    // Memory data arrives during the rvalid cycle; afterwards the captured copy is shown.
    assign f_rdata = f_rvalid ? mem_rdata : f_hold;
    assign l_rdata = l_rvalid ? mem_rdata : l_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= LOADER;
            f_gnt       <= 1'b0;
            l_gnt       <= 1'b0;
            f_rvalid    <= 1'b0;
            l_rvalid    <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            f_pend      <= 1'b0;
            l_pend      <= 1'b0;
            f_hold      <= '0;
            l_hold      <= '0;
        end else begin
            f_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            if (f_rvalid)
                f_hold <= mem_rdata;
            if (l_rvalid)
                l_hold <= mem_rdata;
            case (state)
                IDLE: begin
                    if (f_elig || l_req) begin
                        state       <= ISSUE;
                        mem_en      <= 1'b1;
                        mem_we      <= ~f_win & l_we;
                        mem_addr    <= f_win ? f_addr[DEPTH_W+1:2] : l_addr[DEPTH_W+1:2];
                        mem_wdata   <= f_win ? '0 : l_wdata;
                        f_gnt       <= f_win;
                        l_gnt       <= ~f_win;
                        last_winner <= f_win ? FETCH : LOADER;
                        f_pend      <= f_win;
                        l_pend      <= ~f_win & ~l_we;
                    end
                end
                ISSUE: begin
                    state    <= IDLE;
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    f_gnt    <= 1'b0;
                    l_gnt    <= 1'b0;
                    f_rvalid <= f_pend;
                    l_rvalid <= l_pend;
                    f_pend   <= 1'b0;
                    l_pend   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed vector bench for imem_port_arbiter with a synchronous-read memory model.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req = 1'b0, l_we = 1'b0, l_done = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem [32];

    int nvec = 0;
    int nmis = 0;

    localparam logic [31:0] K5 = 32'h2002_0005;
    localparam logic [31:0] K3 = 32'h2000_0003;
    localparam logic [31:0] W5 = 32'h2005_0008;
    localparam logic [31:0] W3 = 32'h2003_0006;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    imem_port_arbiter #(.DEPTH_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = {16'h2000 | 16'(i), 16'(i + 3)};
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic        f_gnt, l_gnt, mem_en, mem_we;
        logic [4:0]  mem_addr;
        logic [31:0] mem_wdata;
        logic        f_rvalid, l_rvalid;
        logic [31:0] f_rdata, l_rdata;
    } out_t;

    typedef struct packed {
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req, l_we;
        logic [31:0] l_addr, l_wdata;
        out_t        exp;
    } vec_t;

    function automatic out_t cur();
        return '{f_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                 f_rvalid, l_rvalid, f_rdata, l_rdata};
    endfunction

    function automatic out_t mko(logic fg, logic lg, logic en, logic we, logic [4:0] a,
                                 logic [31:0] wd, logic fv, logic lv,
                                 logic [31:0] frd, logic [31:0] lrd);
        return '{fg, lg, en, we, a, wd, fv, lv, frd, lrd};
    endfunction

    function automatic vec_t mkv(logic fr, logic [31:0] fa, logic lr, logic lw,
                                 logic [31:0] la, logic [31:0] lwd, out_t e);
        return '{fr, fa, lr, lw, la, lwd, e};
    endfunction

    task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_raw();
        f_req = 0; l_req = 0; l_we = 0; l_done = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        rst = 1;
        step();
        step();
        check("reset_state", cur(), '0);
        rst = 0;
    endtask

    task automatic reset_dut();
        reset_raw();
`ifdef IMEM_BOOT_HOLD_EN
        l_done = 1;
        step();
        l_done = 0;
`endif
    endtask

    vec_t vt [14];

    initial begin
        vt[0]  = mkv(0, 32'h0,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,0,32'h0,0,0,32'h0,32'h0));
        vt[1]  = mkv(1, 32'h8,  0, 0, 32'h0,  32'h0, mko(1,0,1,0,2,32'h0,0,0,32'h0,32'h0));
        vt[2]  = mkv(0, 32'h0,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,2,32'h0,1,0,K5,32'h0));
        vt[3]  = mkv(0, 32'h0,  1, 1, 32'h10, DB,    mko(0,1,1,1,4,DB,0,0,K5,32'h0));
        vt[4]  = mkv(0, 32'h0,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,4,DB,0,0,K5,32'h0));
        vt[5]  = mkv(0, 32'h0,  1, 0, 32'h10, 32'h0, mko(0,1,1,0,4,32'h0,0,0,K5,32'h0));
        vt[6]  = mkv(0, 32'h0,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,4,32'h0,0,1,K5,DB));
        vt[7]  = mkv(1, 32'h83, 0, 0, 32'h0,  32'h0, mko(1,0,1,0,0,32'h0,0,0,K5,DB));
        vt[8]  = mkv(0, 32'h0,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,0,32'h0,1,0,K3,DB));
        vt[9]  = mkv(1, 32'hC,  1, 0, 32'h14, 32'h0, mko(0,1,1,0,5,32'h0,0,0,K3,DB));
        vt[10] = mkv(1, 32'hC,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,5,32'h0,0,1,K3,W5));
        vt[11] = mkv(1, 32'hC,  0, 0, 32'h0,  32'h0, mko(1,0,1,0,3,32'h0,0,0,K3,W5));
        vt[12] = mkv(0, 32'h0,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,3,32'h0,1,0,W3,W5));
        vt[13] = mkv(0, 32'h0,  0, 0, 32'h0,  32'h0, mko(0,0,0,0,3,32'h0,0,0,W3,W5));

        reset_dut();
        for (int i = 0; i < 14; i++) begin
            f_req = vt[i].f_req;  f_addr = vt[i].f_addr;
            l_req = vt[i].l_req;  l_we = vt[i].l_we;
            l_addr = vt[i].l_addr; l_wdata = vt[i].l_wdata;
            step();
            check($sformatf("vec%0d", i), cur(), vt[i].exp);
        end

        // Both requesters held high from reset: F, -, L, -, F, -, L, -
        reset_dut();
        f_req = 1; f_addr = 32'h4; l_req = 1; l_we = 0; l_addr = 32'h8;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] e;
            step();
            case (c % 4)
                0: e = 4'b1000;
                1: e = 4'b0010;
                2: e = 4'b0100;
                default: e = 4'b0001;
            endcase
            check($sformatf("tie_c%0d", c), {104'h0, f_gnt, l_gnt, f_rvalid, l_rvalid}, {104'h0, e});
        end
        f_req = 0; l_req = 0;
        step();
        step();

        // Reset asserted mid-ISSUE: outputs clear at once, read completes silently.
        reset_dut();
        f_req = 1; f_addr = 32'h8;
        step();
        check("rst_pre_gnt", cur(), mko(1,0,1,0,2,32'h0,0,0,32'h0,32'h0));
        f_req = 0;
        #1 rst = 1;
        #1 check("rst_immediate", cur(), '0);
        #1 rst = 0;
`ifdef IMEM_BOOT_HOLD_EN
        l_done = 1;
`endif
        step();
        l_done = 0;
        check("rst_no_rvalid", cur(), '0);
        f_req = 1; f_addr = 32'hC;
        step();
        check("rst_after_gnt", cur(), mko(1,0,1,0,3,32'h0,0,0,32'h0,32'h0));
        f_req = 0;
        step();
        check("rst_after_rvalid", cur(), mko(0,0,0,0,3,32'h0,1,0,W3,32'h0));

`ifdef IMEM_BOOT_HOLD_EN
        reset_raw();
        f_req = 1; f_addr = 32'h8;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("boot_hold_c%0d", c), {107'h0, f_gnt}, 108'h0);
        end
        l_done = 1;
        step();
        l_done = 0;
        check("boot_done_edge", {107'h0, f_gnt}, 108'h0);
        step();
        check("boot_first_gnt", {107'h0, f_gnt}, 108'h1);
        f_req = 0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
